// File: rtl/mpsk_modulator_if.sv
// Word-stream handshake into the M-PSK modulator: one DATA_WIDTH word plus its modulation mode.
interface mpsk_modulator_if #(
    parameter int DATA_WIDTH = 12
);
    logic [1:0]            mode;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_valid;
    logic                  s_ready;

    modport master (output mode, s_data, s_valid, input s_ready);
    modport slave  (input mode, s_data, s_valid, output s_ready);
endinterface

// File: rtl/mpsk_modulator.sv
// BPSK/QPSK/8PSK Gray-coded modulator: symbols select a phase offset into an external
// registered sine ROM; output is aligned to the ROM delay by a short valid pipeline.
module mpsk_modulator #(
    parameter int SAMPLE_NUMBER = 256,
    parameter int SAMPLE_WIDTH  = 12,
    parameter int DATA_WIDTH    = 12,
    localparam int ADDR_WIDTH   = $clog2(SAMPLE_NUMBER)
) (
    input  logic                    clk,
    input  logic                    arstn,
    input  logic                    en,
    mpsk_modulator_if.slave         s,
    output logic [ADDR_WIDTH-1:0]   sine_addr,
    input  logic [SAMPLE_WIDTH-1:0] sine_in,
    output logic [SAMPLE_WIDTH-1:0] signal_out,
    output logic                    out_valid,
    output logic                    sym_start,
    output logic                    busy
);
    localparam int STAGES = 2;
    localparam int SYM_W  = $clog2(DATA_WIDTH);
    localparam logic [SYM_W-1:0]      LAST_K1  = SYM_W'(DATA_WIDTH - 1);
    localparam logic [SYM_W-1:0]      LAST_K2  = SYM_W'(DATA_WIDTH / 2 - 1);
    localparam logic [SYM_W-1:0]      LAST_K3  = SYM_W'(DATA_WIDTH / 3 - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_PH  = ADDR_WIDTH'(SAMPLE_NUMBER - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   phase_cnt;
    logic [SYM_W-1:0]        sym_cnt;
    logic [DATA_WIDTH-1:0]   shreg;
    logic [1:0]              k_q;
    logic [SYM_W-1:0]        last_sym;
    logic [ADDR_WIDTH-1:0]   offset;
    logic                    b2, b1, b0;
    logic                    last_sample, word_end, accept;
    logic [STAGES:1]         vld_pipe, sof_pipe;

    function automatic logic [1:0] bits_per_sym(input logic [1:0] m);
        case (m)
            2'd1:    return 2'd2;
            2'd2:    return 2'd3;
            default: return 2'd1;
        endcase
    endfunction

    always_comb begin
        case (k_q)
            2'd2:    last_sym = LAST_K2;
            2'd3:    last_sym = LAST_K3;
            default: last_sym = LAST_K1;
        endcase
    end

    assign b2 = shreg[DATA_WIDTH-1];
    assign b1 = shreg[DATA_WIDTH-2];
    assign b0 = shreg[DATA_WIDTH-3];

    // Gray-decoded symbol index scaled to a fraction of the carrier period.
    always_comb begin
        case (k_q)
            2'd2:    offset = ADDR_WIDTH'({b2, b2 ^ b1}) << (ADDR_WIDTH - 2);
            2'd3:    offset = ADDR_WIDTH'({b2, b2 ^ b1, b2 ^ b1 ^ b0}) << (ADDR_WIDTH - 3);
            default: offset = ADDR_WIDTH'(b2) << (ADDR_WIDTH - 1);
        endcase
    end

    assign busy        = (state == RUN);
    assign sine_addr   = busy ? phase_cnt + offset : '0;
    assign last_sample = (phase_cnt == LAST_PH);
    assign word_end    = busy && last_sample && (sym_cnt == last_sym);
    assign s.s_ready   = arstn && en && ((state == IDLE) || word_end);
    assign accept      = s.s_valid && s.s_ready;

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state     <= IDLE;
            phase_cnt <= '0;
            sym_cnt   <= '0;
            shreg     <= '0;
            k_q       <= 2'd1;
        end else if (en) begin
            if (accept) begin
                // Also covers the gapless hand-over from the last sample of the previous word.
                state     <= RUN;
                shreg     <= s.s_data;
                k_q       <= bits_per_sym(s.mode);
                phase_cnt <= '0;
                sym_cnt   <= '0;
            end else if (state == RUN) begin
                phase_cnt <= phase_cnt + 1'b1;
                if (last_sample) begin
                    if (word_end) begin
                        state   <= IDLE;
                        shreg   <= '0;
                        sym_cnt <= '0;
                    end else begin
                        shreg   <= shreg << k_q;
                        sym_cnt <= sym_cnt + 1'b1;
                    end
                end
            end
        end
    end

    // Stage 1 runs alongside the ROM register; stage 2 is the output register.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            vld_pipe   <= '0;
            sof_pipe   <= '0;
            signal_out <= '0;
        end else if (en) begin
            vld_pipe   <= {vld_pipe[STAGES-1:1], busy};
            sof_pipe   <= {sof_pipe[STAGES-1:1], busy && (phase_cnt == '0)};
            signal_out <= vld_pipe[1] ? sine_in : '0;
        end
    end

    assign out_valid = vld_pipe[STAGES];
    assign sym_start = sof_pipe[STAGES];
endmodule

// File: tb/tb_mpsk_modulator.sv
// Directed bench for mpsk_modulator: driver pushes expected samples, monitor pops and compares.
module tb_mpsk_modulator;
    logic        clk = 1'b0;
    logic        arstn = 1'b0;
    logic        en = 1'b1;
    logic [7:0]  sine_addr;
    logic [11:0] sine_in = '0;
    logic [11:0] signal_out;
    logic        out_valid, sym_start, busy;

    int checks = 0;
    int errors = 0;
    bit chk_gap = 1'b0;

    typedef struct {
        logic [11:0] smp;
        logic        sof;
    } exp_t;
    exp_t exp_q[$];

    mpsk_modulator_if #(.DATA_WIDTH(12)) sif ();

    mpsk_modulator #(
        .SAMPLE_NUMBER(256), .SAMPLE_WIDTH(12), .DATA_WIDTH(12)
    ) dut (
        .clk(clk), .arstn(arstn), .en(en), .s(sif),
        .sine_addr(sine_addr), .sine_in(sine_in), .signal_out(signal_out),
        .out_valid(out_valid), .sym_start(sym_start), .busy(busy)
    );

    always #5 clk = ~clk;

    // Distinct value per address so any address error shows up in the data.
    function automatic logic [11:0] rom(input logic [7:0] a);
        return {a, 4'h5};
    endfunction

    always @(posedge clk) if (en) sine_in <= rom(sine_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push_word(input int offs[12], input int nsym);
        for (int sy = 0; sy < nsym; sy++)
            for (int p = 0; p < 256; p++)
                exp_q.push_back('{rom(8'(p + offs[sy])), (p == 0)});
    endtask

    task automatic send(input logic [1:0] m, input logic [11:0] d, input int offs[12],
                        input int nsym, input bit hold, output int waited);
        sif.mode = m; sif.s_data = d; sif.s_valid = 1'b1; waited = 0;
        while (!sif.s_ready && waited < 8000) begin
            @(posedge clk); #1; waited++;
        end
        if (!sif.s_ready) begin
            chk("s_ready_timeout", 32'(waited), 32'(0));
            sif.s_valid = 1'b0;
            return;
        end
        push_word(offs, nsym);
        @(posedge clk); #1;
        if (!hold) sif.s_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 8000) begin
            @(posedge clk); #1; n++;
        end
        chk({name, "_drain_left"}, 32'(exp_q.size()), 32'(0));
        repeat (3) @(posedge clk);
        #1;
        chk({name, "_idle_busy"}, 32'(busy), 32'(0));
        chk({name, "_idle_valid"}, 32'(out_valid), 32'(0));
        chk({name, "_idle_out"}, 32'(signal_out), 32'(0));
        chk({name, "_idle_addr"}, 32'(sine_addr), 32'(0));
    endtask

    // Monitor: one pop per enabled edge that leaves a valid sample on the outputs.
    initial begin
        bit en_s;
        bit prev_v = 1'b0;
        exp_t e;
        forever begin
            @(posedge clk); en_s = en;
            @(negedge clk);
            if (arstn && en_s) begin
                if (chk_gap && prev_v && !out_valid && exp_q.size() != 0)
                    chk("out_valid_gap", 32'(out_valid), 32'(1));
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_sample", 32'(signal_out), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("signal_out", 32'(signal_out), 32'(e.smp));
                        chk("sym_start", 32'(sym_start), 32'(e.sof));
                    end
                end
                prev_v = out_valid;
            end
        end
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int offs_a5c[12] = '{128, 0, 128, 0, 0, 128, 0, 128, 128, 128, 0, 0};
        sif.s_valid = 1'b0; sif.s_data = '0; sif.mode = 2'd0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out", 32'(signal_out), 32'(0));
        chk("rst_valid", 32'(out_valid), 32'(0));
        chk("rst_sof", 32'(sym_start), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_addr", 32'(sine_addr), 32'(0));
        chk("rst_ready", 32'(sif.s_ready), 32'(0));
        arstn = 1'b1;
        #1 chk("idle_ready", 32'(sif.s_ready), 32'(1));

        // BPSK single word, busy for exactly 12*256 cycles
        send(2'd0, 12'hA5C, offs_a5c, 12, 1'b0, w);
        chk("t1_wait", 32'(w), 32'(0));
        chk("t1_addr0", 32'(sine_addr), 32'(128));
        repeat (3071) @(posedge clk);
        #1 chk("t1_busy_last", 32'(busy), 32'(1));
        @(posedge clk); #1;
        chk("t1_busy_end", 32'(busy), 32'(0));
        wait_drain("t1");

        // QPSK
        send(2'd1, 12'b00_01_11_10_00_01, '{0, 64, 128, 192, 0, 64, 0, 0, 0, 0, 0, 0}, 6, 1'b0, w);
        chk("t2_addr0", 32'(sine_addr), 32'(0));
        wait_drain("t2");

        // 8PSK, then mode 3 behaves as BPSK
        send(2'd2, 12'b010_111_100_000, '{96, 160, 224, 0, 0, 0, 0, 0, 0, 0, 0, 0}, 4, 1'b0, w);
        chk("t3_addr0", 32'(sine_addr), 32'(96));
        wait_drain("t3");
        send(2'd3, 12'hA5C, offs_a5c, 12, 1'b0, w);
        chk("t3m3_addr0", 32'(sine_addr), 32'(128));
        wait_drain("t3m3");

        // Back-to-back BPSK words with s_valid held
        chk_gap = 1'b1;
        send(2'd0, 12'h0F3, '{0, 0, 0, 0, 128, 128, 128, 128, 0, 0, 128, 128}, 12, 1'b1, w);
        chk("t4_wait0", 32'(w), 32'(0));
        send(2'd0, 12'hC30, '{128, 128, 0, 0, 0, 0, 128, 128, 0, 0, 0, 0}, 12, 1'b0, w);
        chk("t4_wait1", 32'(w), 32'(3071));
        chk("t4_ready_low", 32'(sif.s_ready), 32'(0));
        chk("t4_addr0", 32'(sine_addr), 32'(128));
        wait_drain("t4");
        chk_gap = 1'b0;

        // Stall for 10 cycles at phase_cnt=37 of a QPSK symbol with offset 192
        send(2'd1, 12'b10_00_01_11_10_00, '{192, 0, 64, 128, 192, 0, 0, 0, 0, 0, 0, 0}, 6, 1'b0, w);
        repeat (37) @(posedge clk);
        #1 chk("t5_addr37", 32'(sine_addr), 32'(229));
        en = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            chk("t5_hold_addr", 32'(sine_addr), 32'(229));
            chk("t5_hold_out", 32'(signal_out), 32'(12'hE35));
            chk("t5_hold_valid", 32'(out_valid), 32'(1));
            chk("t5_hold_ready", 32'(sif.s_ready), 32'(0));
        end
        en = 1'b1;
        @(posedge clk); #1;
        chk("t5_resume_addr", 32'(sine_addr), 32'(230));
        wait_drain("t5");

        // Reset at sample 500 of a word, then a fresh 8PSK word
        send(2'd0, 12'hFFF, '{128, 128, 128, 128, 128, 128, 128, 128, 128, 128, 128, 128}, 12, 1'b0, w);
        repeat (500) @(posedge clk);
        #1 arstn = 1'b0;
        #1;
        chk("t6_rst_out", 32'(signal_out), 32'(0));
        chk("t6_rst_valid", 32'(out_valid), 32'(0));
        chk("t6_rst_busy", 32'(busy), 32'(0));
        chk("t6_rst_addr", 32'(sine_addr), 32'(0));
        chk("t6_rst_ready", 32'(sif.s_ready), 32'(0));
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 arstn = 1'b1;
        #1;
        chk("t6_idle_busy", 32'(busy), 32'(0));
        chk("t6_idle_ready", 32'(sif.s_ready), 32'(1));
        send(2'd2, 12'b111_011_001_110, '{160, 64, 32, 128, 0, 0, 0, 0, 0, 0, 0, 0}, 4, 1'b0, w);
        chk("t6_addr0", 32'(sine_addr), 32'(160));
        wait_drain("t6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
